// File: rtl/l2_row_sched.sv
// l2_row_sched: frame-level sequencer for the layer-2 convolution datapath.
// Each frame fetches ROWS row vectors from the layer-1 store. Each row is
// latched into a stable buffer, the datapath gets a start pulse, and the
// sequencer waits for the per-row completion before it advances. After the
// last row it holds frame_done until the transmitter acknowledges.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   frame_go    start-of-frame request (accepted only when idle)
//   l1_rd       one-cycle row-read request; l1_addr is the row index
//   l1_vld      row data valid; l1_din is the row data
//   row_out     latched row buffer feeding the datapath din
//   strt        one-cycle datapath start pulse
//   row_done    datapath row-complete pulse
//   tx_done     downstream frame acknowledge; also a global abort
//   busy        high in every state except idle
//   frame_done  high while waiting for tx_done
//   err         sticky watchdog flag
module l2_row_sched #(
  parameter int ROWS    = 12,
  parameter int ROW_LEN = 18,
  parameter int DATA_W  = 18,
  parameter int TMO     = 63
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_go,
  output logic                             l1_rd,
  output logic [$clog2(ROWS)-1:0]          l1_addr,
  input  logic                             l1_vld,
  input  logic [ROW_LEN-1:0][DATA_W-1:0]   l1_din,
  output logic [ROW_LEN-1:0][DATA_W-1:0]   row_out,
  output logic                             strt,
  input  logic                             row_done,
  input  logic                             tx_done,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             err
);

  localparam int AW = $clog2(ROWS);
  localparam int WW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t                           state, state_nxt;
  logic [AW-1:0]                    row_cnt, row_cnt_nxt;
  logic [WW-1:0]                    wdog, wdog_nxt;
  logic                             err_nxt;
  logic [ROW_LEN-1:0][DATA_W-1:0]   row_out_nxt;
  logic                             adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      wdog    <= '0;
      err     <= 1'b0;
      row_out <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      wdog    <= wdog_nxt;
      err     <= err_nxt;
      row_out <= row_out_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    wdog_nxt    = wdog;
    err_nxt     = err;
    row_out_nxt = row_out;
    adv         = 1'b0;
    // tx_done aborts from any state and outranks every other input;
    // the row buffer and err are deliberately left untouched.
    if (tx_done) begin
      state_nxt   = S_IDLE;
      row_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            state_nxt   = S_FETCH;
            row_cnt_nxt = '0;
          end
        end
        S_FETCH: state_nxt = S_WAIT;
        S_WAIT: begin
          if (l1_vld) begin
            row_out_nxt = l1_din;
            state_nxt   = S_START;
          end
        end
        S_START: begin
          wdog_nxt  = '0;
          state_nxt = S_RUN;
        end
        S_RUN: begin
          // A watchdog expiry stands in for row_done so the frame keeps moving.
          if (row_done) begin
            adv = 1'b1;
          end else if (wdog == WW'(TMO)) begin
            err_nxt = 1'b1;
            adv     = 1'b1;
          end else begin
            wdog_nxt = wdog + WW'(1);
          end
          if (adv) begin
            if (row_cnt == AW'(ROWS - 1)) begin
              state_nxt = S_DONE;
            end else begin
              row_cnt_nxt = row_cnt + AW'(1);
              state_nxt   = S_FETCH;
            end
          end
        end
        S_DONE: state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign l1_rd      = (state == S_FETCH);
  assign strt       = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign l1_addr    = row_cnt;

endmodule

// File: tb/tb_l2_row_sched.sv
// Directed testbench for l2_row_sched: reset, full frame, delayed data,
// spurious inputs, abort via tx_done, and the RUN watchdog.
module tb_l2_row_sched;

  localparam int ROWS    = 12;
  localparam int ROW_LEN = 18;
  localparam int DATA_W  = 18;
  localparam int TMO     = 63;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            frame_go;
  logic                            l1_rd;
  logic [$clog2(ROWS)-1:0]         l1_addr;
  logic                            l1_vld;
  logic [ROW_LEN-1:0][DATA_W-1:0]  l1_din;
  logic [ROW_LEN-1:0][DATA_W-1:0]  row_out;
  logic                            strt;
  logic                            row_done;
  logic                            tx_done;
  logic                            busy;
  logic                            frame_done;
  logic                            err;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int strt_cnt  = 0;
  int last_strt = 0;

  l2_row_sched #(
    .ROWS    (ROWS),
    .ROW_LEN (ROW_LEN),
    .DATA_W  (DATA_W),
    .TMO     (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_go   (frame_go),
    .l1_rd      (l1_rd),
    .l1_addr    (l1_addr),
    .l1_vld     (l1_vld),
    .l1_din     (l1_din),
    .row_out    (row_out),
    .strt       (strt),
    .row_done   (row_done),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (strt) strt_cnt++;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int base);
    for (int i = 0; i < ROW_LEN; i++) l1_din[i] = DATA_W'(base + i);
  endtask

  // Entered in the FETCH cycle; returns in the START cycle.
  task automatic fetch_row(input int r, input int base, input int delay,
                           input bit chk_period, input bit spur_rd);
    check("fetch_l1_rd", {31'd0, l1_rd}, 1);
    check("fetch_l1_addr", {28'd0, l1_addr}, r);
    check("fetch_busy", {31'd0, busy}, 1);
    tick();
    for (int d = 0; d < delay; d++) begin
      row_done = spur_rd && (d == 0);
      check("wait_hold", {29'd0, l1_rd, strt, busy}, 32'b001);
      tick();
    end
    row_done = 1'b0;
    set_row(base);
    l1_vld = 1'b1;
    tick();
    l1_vld = 1'b0;
    check("strt", {31'd0, strt}, 1);
    check("row_out5", {14'd0, row_out[5]}, base + 5);
    if (chk_period) check("strt_period", cyc - last_strt, 9);
    last_strt = cyc;
  endtask

  // Entered k-1 cycles into RUN... precisely: entered in START, drives
  // row_done in the k-th RUN cycle, returns in the following cycle.
  task automatic run_row(input int k, input bit abort);
    repeat (k) tick();
    row_done = 1'b1;
    tx_done  = abort;
    tick();
    row_done = 1'b0;
    tx_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_go = 1'b1; l1_vld = 1'b0; row_done = 1'b0; tx_done = 1'b0;
    l1_din = '0;

    // Reset
    repeat (2) tick();
    check("rst_l1_rd", {31'd0, l1_rd}, 0);
    check("rst_strt", {31'd0, strt}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_l1_addr", {28'd0, l1_addr}, 0);
    check("rst_row_out", {31'd0, |row_out}, 0);
    rst = 1'b0; frame_go = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 0);
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    strt_cnt = 0;

    // Full frame
    for (int r = 0; r < ROWS; r++) begin
      fetch_row(r, r * 32, 0, r > 0, 1'b0);
      run_row(6, 1'b0);
    end
    check("f1_frame_done", {31'd0, frame_done}, 1);
    check("f1_strt_cnt", strt_cnt, 12);
    check("f1_err", {31'd0, err}, 0);
    for (int i = 0; i < 20; i++) begin
      check("f1_done_hold", {29'd0, frame_done, busy, l1_rd}, 32'b110);
      tick();
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("f1_idle_busy", {31'd0, busy}, 0);
    check("f1_idle_frame_done", {31'd0, frame_done}, 0);
    tick();
    check("f1_idle_stays", {29'd0, busy, l1_rd, strt}, 0);

    // Delayed data, spurious inputs, abort at row 5
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    fetch_row(0, 'h1000, 10, 1'b0, 1'b1);
    tick();
    set_row('h3000);
    l1_vld = 1'b1; frame_go = 1'b1;
    tick();
    l1_vld = 1'b0; frame_go = 1'b0;
    check("spur_row_out5", {14'd0, row_out[5]}, 'h1000 + 5);
    check("spur_run_outs", {29'd0, l1_rd, strt, busy}, 32'b001);
    run_row(4, 1'b0);
    for (int r = 1; r < 5; r++) begin
      fetch_row(r, 'h1000 + r * 32, 0, 1'b1, 1'b0);
      run_row(6, 1'b0);
    end
    fetch_row(5, 'h1000 + 5 * 32, 0, 1'b1, 1'b0);
    run_row(6, 1'b1);
    check("abort_outs", {28'd0, busy, l1_rd, strt, frame_done}, 0);
    check("abort_row_out_held", {14'd0, row_out[5]}, 'h1000 + 5 * 32 + 5);
    check("abort_err", {31'd0, err}, 0);
    tick();
    check("abort_stays_idle", {29'd0, busy, l1_rd, strt}, 0);
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;

    // Watchdog: no row_done for row 0
    fetch_row(0, 'h2000, 0, 1'b0, 1'b0);
    repeat (64) tick();
    check("wdog_pre_err", {31'd0, err}, 0);
    check("wdog_pre_outs", {29'd0, l1_rd, strt, busy}, 32'b001);
    tick();
    check("wdog_err", {31'd0, err}, 1);
    for (int r = 1; r < ROWS; r++) begin
      fetch_row(r, 'h2000 + r * 32, 0, 1'b0, 1'b0);
      run_row(6, 1'b0);
    end
    check("wdog_frame_done", {31'd0, frame_done}, 1);
    check("wdog_err_done", {31'd0, err}, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("wdog_idle_busy", {31'd0, busy}, 0);
    check("wdog_err_sticky", {31'd0, err}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wdog_err_cleared", {31'd0, err}, 0);
    check("final_row_out", {31'd0, |row_out}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
